// File: rtl/regfile_wr_queue.sv
// Write-back queue: buffers {rd, data} and drains one per cycle as a one-hot enable.
// Define WRQ_BYPASS_EN to add a newest-first bypass lookup over queue and output reg.
module regfile_wr_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_addr,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     rf_stall,
    output logic [(1<<ADDR_W)-1:0]   wr_en_onehot,
    output logic [DATA_W-1:0]        wr_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
`ifdef WRQ_BYPASS_EN
    ,
    input  logic [ADDR_W-1:0]        byp_addr,
    output logic                     byp_hit,
    output logic [DATA_W-1:0]        byp_data
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int OW = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] XZR = '1;

    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [ADDR_W-1:0] addr_d [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d;
    logic [PW-1:0]     tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic [OW-1:0]     wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic push;
    logic pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == CW'(DEPTH));
    assign in_ready = !full;
    assign count    = count_q;

    assign wr_en_onehot = wr_en_q;
    assign wr_data      = wr_data_q;

    // XZR requests complete the handshake but are never stored
    assign push = in_valid && in_ready && (in_addr != XZR);
    assign pop  = !empty && !rf_stall;

    always_comb begin
        addr_d    = addr_q;
        data_d    = data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        wr_en_d   = '0;
        wr_data_d = wr_data_q;
        count_d   = count_q + CW'(push) - CW'(pop);
        if (push) begin
            addr_d[tail_q] = in_addr;
            data_d[tail_q] = in_data;
            tail_d         = tail_q + PW'(1);
        end
        if (pop) begin
            wr_en_d   = OW'(1) << addr_q[head_q];
            wr_data_d = data_q[head_q];
            head_d    = head_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= addr_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

`ifdef WRQ_BYPASS_EN
    logic [PW-1:0] byp_idx;

    // Output reg is oldest; walking the queue oldest-to-newest lets newer hits win
    always_comb begin
        byp_hit  = 1'b0;
        byp_data = '0;
        byp_idx  = '0;
        if (byp_addr != XZR) begin
            if (wr_en_q[byp_addr]) begin
                byp_hit  = 1'b1;
                byp_data = wr_data_q;
            end
            for (int i = 0; i < DEPTH; i++) begin
                byp_idx = head_q + PW'(i);
                if ((CW'(i) < count_q) && (addr_q[byp_idx] == byp_addr)) begin
                    byp_hit  = 1'b1;
                    byp_data = data_q[byp_idx];
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_regfile_wr_queue.sv
// Self-checking bench for regfile_wr_queue: vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_regfile_wr_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [63:0] in_data;
    logic        rf_stall;
    logic [31:0] wr_en_onehot;
    logic [63:0] wr_data;
    logic [2:0]  count;
    logic        empty;
    logic        full;
`ifdef WRQ_BYPASS_EN
    logic [4:0]  byp_addr;
    logic        byp_hit;
    logic [63:0] byp_data;
`endif

    int tests;
    int fails;

    regfile_wr_queue #(.DEPTH(DEPTH), .DATA_W(64), .ADDR_W(5)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_data      (in_data),
        .rf_stall     (rf_stall),
        .wr_en_onehot (wr_en_onehot),
        .wr_data      (wr_data),
        .count        (count),
        .empty        (empty),
        .full         (full)
`ifdef WRQ_BYPASS_EN
        ,
        .byp_addr     (byp_addr),
        .byp_hit      (byp_hit),
        .byp_data     (byp_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [4:0]  a;
        logic [63:0] d;
        logic        s;
        logic [31:0] en;
        logic [63:0] wd;
        int          cnt;
    } vec_t;

    typedef struct {
        logic [4:0]  a;
        logic [63:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_en;
    logic [63:0] m_data;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [63:0] d, input logic s);
        in_valid = v;
        in_addr  = a;
        in_data  = d;
        rf_stall = s;
    endtask

    task automatic model_step();
        bit can_push;
        can_push = (mq.size() < DEPTH);
        if (mq.size() > 0 && !rf_stall) begin
            m_en   = 32'd1 << mq[0].a;
            m_data = mq[0].d;
            void'(mq.pop_front());
        end else begin
            m_en = '0;
        end
        if (in_valid && can_push && in_addr != 5'd31)
            mq.push_back('{in_addr, in_data});
    endtask

`ifdef WRQ_BYPASS_EN
    task automatic model_byp(input logic [4:0] a, output logic hit, output logic [63:0] d);
        hit = 1'b0;
        d   = '0;
        if (a != 5'd31) begin
            for (int i = mq.size() - 1; i >= 0; i--) begin
                if (!hit && mq[i].a == a) begin
                    hit = 1'b1;
                    d   = mq[i].d;
                end
            end
            if (!hit && m_en[a]) begin
                hit = 1'b1;
                d   = m_data;
            end
        end
    endtask
`endif

    vec_t tbl [15];

    initial begin
        logic [4:0]  sa [10];
        logic [63:0] sd [10];
`ifdef WRQ_BYPASS_EN
        logic        eh;
        logic [63:0] ed;
`endif
        tests = 0;
        fails = 0;

        tbl[0]  = '{1'b1, 5'd5,  64'hA5,   1'b0, 32'h0,        64'hA5 & 64'h0, 1};
        tbl[1]  = '{1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0020, 64'hA5,  0};
        tbl[2]  = '{1'b0, 5'd0,  64'h0,    1'b0, 32'h0,        64'hA5,  0};
        tbl[3]  = '{1'b1, 5'd31, 64'hFFFF, 1'b0, 32'h0,        64'hA5,  0};
        tbl[4]  = '{1'b0, 5'd0,  64'h0,    1'b0, 32'h0,        64'hA5,  0};
        tbl[5]  = '{1'b1, 5'd1,  64'h101,  1'b1, 32'h0,        64'hA5,  1};
        tbl[6]  = '{1'b1, 5'd2,  64'h102,  1'b1, 32'h0,        64'hA5,  2};
        tbl[7]  = '{1'b1, 5'd3,  64'h103,  1'b1, 32'h0,        64'hA5,  3};
        tbl[8]  = '{1'b1, 5'd4,  64'h104,  1'b1, 32'h0,        64'hA5,  4};
        tbl[9]  = '{1'b1, 5'd5,  64'h105,  1'b1, 32'h0,        64'hA5,  4};
        tbl[10] = '{1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0002, 64'h101, 3};
        tbl[11] = '{1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0004, 64'h102, 2};
        tbl[12] = '{1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0008, 64'h103, 1};
        tbl[13] = '{1'b0, 5'd0,  64'h0,    1'b0, 32'h0000_0010, 64'h104, 0};
        tbl[14] = '{1'b0, 5'd0,  64'h0,    1'b0, 32'h0,        64'h104, 0};

        // Reset
        reset_n = 1'b0;
        drive(1'b0, 5'd0, 64'h0, 1'b0);
`ifdef WRQ_BYPASS_EN
        byp_addr = 5'd0;
`endif
        #1;
        chk("rst_en", wr_en_onehot, 0);
        chk("rst_data", wr_data, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ready", in_ready, 1);
        tick();
        tick();
        reset_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            drive(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].s);
            if (i == 9) chk("full_ready", in_ready, 0);
            tick();
            chk($sformatf("vec%0d_en", i), wr_en_onehot, tbl[i].en);
            chk($sformatf("vec%0d_data", i), wr_data, tbl[i].wd);
            chk($sformatf("vec%0d_count", i), count, 64'(tbl[i].cnt));
            chk($sformatf("vec%0d_full", i), full, tbl[i].cnt == DEPTH);
            chk($sformatf("vec%0d_empty", i), empty, tbl[i].cnt == 0);
        end

        // Continuous stream with pointer wrap
        for (int i = 0; i < 10; i++) begin
            sa[i] = 5'(i + 10);
            sd[i] = 64'hDEAD_0000 + 64'(i);
        end
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, sa[i], sd[i], 1'b0);
            tick();
            chk($sformatf("strm%0d_count", i), count, 1);
            if (i > 0) begin
                chk($sformatf("strm%0d_en", i), wr_en_onehot, 32'd1 << sa[i-1]);
                chk($sformatf("strm%0d_data", i), wr_data, sd[i-1]);
            end
        end
        drive(1'b0, 5'd0, 64'h0, 1'b0);
        tick();
        chk("strm_last_en", wr_en_onehot, 32'd1 << sa[9]);
        chk("strm_last_data", wr_data, sd[9]);
        chk("strm_last_count", count, 0);
        tick();
        chk("strm_idle_en", wr_en_onehot, 0);

        // Asynchronous reset mid-operation
        drive(1'b1, 5'd6, 64'h66, 1'b1);
        tick();
        drive(1'b1, 5'd7, 64'h77, 1'b1);
        tick();
        drive(1'b1, 5'd8, 64'h88, 1'b1);
        tick();
        drive(1'b0, 5'd0, 64'h0, 1'b0);
        tick();
        chk("mid_pre_en", wr_en_onehot, 32'd1 << 6);
        chk("mid_pre_count", count, 2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_en", wr_en_onehot, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_empty", empty, 1);
        chk("mid_rst_data", wr_data, 0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("post_rst%0d_en", i), wr_en_onehot, 0);
        end

        // Random traffic against the reference model
        mq.delete();
        m_en   = '0;
        m_data = '0;
        for (int n = 0; n < 400; n++) begin
            drive(($urandom % 4) != 0,
                  (($urandom % 8) == 0) ? 5'd31 : 5'($urandom % 32),
                  {$urandom, $urandom},
                  ($urandom % 4) == 0);
            chk("rnd_ready", in_ready, mq.size() < DEPTH);
            model_step();
            tick();
            chk($sformatf("rnd%0d_en", n), wr_en_onehot, m_en);
            chk($sformatf("rnd%0d_data", n), wr_data, m_data);
            chk($sformatf("rnd%0d_count", n), count, 64'(mq.size()));
            chk("rnd_empty", empty, mq.size() == 0);
            chk("rnd_full", full, mq.size() == DEPTH);
`ifdef WRQ_BYPASS_EN
            byp_addr = (($urandom % 2) == 0 && mq.size() > 0) ? mq[$urandom % mq.size()].a
                                                             : 5'($urandom % 32);
            #1;
            model_byp(byp_addr, eh, ed);
            chk($sformatf("rnd%0d_byp_hit", n), byp_hit, eh);
            chk($sformatf("rnd%0d_byp_data", n), byp_data, ed);
`endif
        end

`ifdef WRQ_BYPASS_EN
        drive(1'b0, 5'd0, 64'h0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        drive(1'b1, 5'd7, 64'h11, 1'b1);
        tick();
        drive(1'b1, 5'd7, 64'h22, 1'b1);
        tick();
        drive(1'b0, 5'd0, 64'h0, 1'b1);
        byp_addr = 5'd7;
        #1;
        chk("byp7_hit", byp_hit, 1);
        chk("byp7_data", byp_data, 64'h22);
        byp_addr = 5'd31;
        #1;
        chk("byp31_hit", byp_hit, 0);
        chk("byp31_data", byp_data, 0);
        byp_addr = 5'd9;
        #1;
        chk("byp_miss_hit", byp_hit, 0);
        chk("byp_miss_data", byp_data, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
